// File: rtl/cpu_run_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_run_control_if
//  Description : Command / status bundle between a host controller and the
//                CPU run-control block (command handshake, divider select,
//                CPU clock-enable, stretched reset and status outputs).
//  Revision    : 1.0  initial release
// ============================================================================
interface cpu_run_control_if #(
    parameter int DIV_W = 4,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [DIV_W-1:0] div_sel;
    logic             cpu_ce;
    logic             cpu_rst;
    logic [1:0]       state;
    logic             done;
    logic [31:0]      ce_count;

    // Host side: issues commands, observes CPU control and status
    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_count,
        output div_sel,
        input  cmd_ready,
        input  cpu_ce,
        input  cpu_rst,
        input  state,
        input  done,
        input  ce_count
    );

    // Run-control side: accepts commands, drives CPU control and status
    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_count,
        input  div_sel,
        output cmd_ready,
        output cpu_ce,
        output cpu_rst,
        output state,
        output done,
        output ce_count
    );
endinterface
`default_nettype wire

// File: rtl/cpu_run_control.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_run_control
//  Description : CPU run controller. Stretches reset to the CPU, then obeys
//                halt / run / burst / soft-reset commands, generating a
//                divided clock-enable and counting the enables it issues.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_run_control #(
    parameter int DIV_W      = 4,
    parameter int CNT_W      = 8,
    parameter int RST_CYCLES = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    cpu_run_control_if.slave     bus
);
    // Reset counter only needs to reach RST_CYCLES-1
    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] C_RST_LAST = RST_W'(RST_CYCLES - 1);

    localparam logic [1:0] C_OP_HALT  = 2'b00;
    localparam logic [1:0] C_OP_RUN   = 2'b01;
    localparam logic [1:0] C_OP_BURST = 2'b10;
    localparam logic [1:0] C_OP_SRST  = 2'b11;

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_HALT  = 2'b01,
        ST_RUN   = 2'b10,
        ST_BURST = 2'b11
    } state_t;

    state_t           state_q,    state_d;
    logic [RST_W-1:0] rst_cnt_q,  rst_cnt_d;
    logic [DIV_W-1:0] div_cnt_q,  div_cnt_d;
    logic [DIV_W-1:0] div_q,      div_d;
    logic [CNT_W-1:0] burst_q,    burst_d;
    logic [31:0]      ce_count_q, ce_count_d;
    logic             done_q,     done_d;

    logic w_active;
    logic w_ce;
    logic w_accept;

    assign w_active = (state_q == ST_RUN) || (state_q == ST_BURST);
    assign w_ce     = w_active && (div_cnt_q == div_q);
    assign w_accept = bus.cmd_valid && (state_q != ST_RESET);

    assign bus.cmd_ready = (state_q != ST_RESET);
    assign bus.cpu_ce    = w_ce;
    assign bus.cpu_rst   = (state_q == ST_RESET);
    assign bus.state     = state_q;
    assign bus.done      = done_q;
    assign bus.ce_count  = ce_count_q;

    // State and datapath registers; hardware reset clears everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RESET;
            rst_cnt_q  <= '0;
            div_cnt_q  <= '0;
            div_q      <= '0;
            burst_q    <= '0;
            ce_count_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            div_cnt_q  <= div_cnt_d;
            div_q      <= div_d;
            burst_q    <= burst_d;
            ce_count_q <= ce_count_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic; an accepted command overrides the current activity,
    // including a burst finishing on the same edge (so no done pulse then)
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        div_cnt_d  = div_cnt_q;
        div_d      = div_q;
        burst_d    = burst_q;
        done_d     = 1'b0;
        ce_count_d = ce_count_q + 32'(w_ce);

        if (w_active) begin
            div_cnt_d = w_ce ? '0 : div_cnt_q + 1'b1;
        end

        case (state_q)
            ST_RESET: begin
                if (rst_cnt_q == C_RST_LAST) begin
                    state_d   = ST_HALT;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_BURST: begin
                if (w_ce) begin
                    burst_d = burst_q - 1'b1;
                    if (burst_q == CNT_W'(1)) begin
                        state_d = ST_HALT;
                        done_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (w_accept) begin
            div_d     = bus.div_sel;
            div_cnt_d = '0;
            burst_d   = bus.cmd_count;
            done_d    = 1'b0;
            case (bus.cmd_op)
                C_OP_HALT: state_d = ST_HALT;
                C_OP_RUN:  state_d = ST_RUN;
                C_OP_BURST: begin
                    if (bus.cmd_count == '0) begin
                        state_d = ST_HALT;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_BURST;
                    end
                end
                C_OP_SRST: begin
                    state_d   = ST_RESET;
                    rst_cnt_d = '0;
                end
                default: state_d = ST_HALT;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cpu_run_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_run_control
//  Description : Directed self-checking bench for cpu_run_control. Each step
//                pushes the expected per-cycle state/ce/done into a queue;
//                every clock the head is popped and compared with the DUT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_run_control;
    localparam logic [1:0] S_RST   = 2'b00;
    localparam logic [1:0] S_HALT  = 2'b01;
    localparam logic [1:0] S_RUN   = 2'b10;
    localparam logic [1:0] S_BURST = 2'b11;

    typedef struct {
        logic [1:0] st;
        logic       ce;
        logic       dn;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    cpu_run_control_if #(.DIV_W(4), .CNT_W(8)) bus ();

    cpu_run_control #(
        .DIV_W      (4),
        .CNT_W      (8),
        .RST_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic expect_cyc(logic [1:0] st, logic ce, logic dn);
        exp_t e;
        e.st = st;
        e.ce = ce;
        e.dn = dn;
        exp_q.push_back(e);
    endtask

    // Advance one clock, sample 1 time unit later and compare with queue head
    task automatic step(string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "/queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "/state"},     32'(bus.state),     32'(e.st));
            chk({tag, "/cpu_ce"},    32'(bus.cpu_ce),    32'(e.ce));
            chk({tag, "/done"},      32'(bus.done),      32'(e.dn));
            chk({tag, "/cpu_rst"},   32'(bus.cpu_rst),   32'(e.st == S_RST));
            chk({tag, "/cmd_ready"}, 32'(bus.cmd_ready), 32'(e.st != S_RST));
        end
    endtask

    task automatic accept_step(string tag);
        step(tag);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic issue(logic [1:0] op, logic [7:0] cnt, logic [3:0] div);
        bus.cmd_op    = op;
        bus.cmd_count = cnt;
        bus.div_sel   = div;
        bus.cmd_valid = 1'b1;
    endtask

    initial begin
        // Hardware reset with a command held valid throughout: it must be ignored
        rst = 1'b1;
        issue(2'b01, 8'd0, 4'd0);
        repeat (3) expect_cyc(S_RST, 1'b0, 1'b0);
        repeat (3) step("rst_hold");
        chk("rst_ce_count", bus.ce_count, 32'd0);
        rst = 1'b0;
        repeat (3) expect_cyc(S_RST, 1'b0, 1'b0);
        expect_cyc(S_HALT, 1'b0, 1'b0);
        repeat (4) step("rst_stretch");
        bus.cmd_valid = 1'b0;
        chk("rst_exit_ce_count", bus.ce_count, 32'd0);
        expect_cyc(S_HALT, 1'b0, 1'b0);
        step("halt_idle");

        // Run, div 2: pulses on cycles 3,6,9,12; later div_sel edits ignored
        issue(2'b01, 8'd0, 4'd2);
        for (int k = 1; k <= 12; k++) expect_cyc(S_RUN, (k % 3) == 0, 1'b0);
        accept_step("run_div2");
        bus.div_sel = 4'd0;
        repeat (11) step("run_div2");
        issue(2'b00, 8'd0, 4'd0);
        repeat (2) expect_cyc(S_HALT, 1'b0, 1'b0);
        accept_step("halt_after_run");
        chk("run_ce_count", bus.ce_count, 32'd4);
        step("halt_hold");
        chk("halt_ce_count_hold", bus.ce_count, 32'd4);

        // Burst 5 at full rate: five pulses, HALT, single done
        issue(2'b10, 8'd5, 4'd0);
        repeat (5) expect_cyc(S_BURST, 1'b1, 1'b0);
        expect_cyc(S_HALT, 1'b0, 1'b1);
        expect_cyc(S_HALT, 1'b0, 1'b0);
        accept_step("burst5");
        repeat (6) step("burst5");
        chk("burst5_ce_count", bus.ce_count, 32'd9);

        // Burst 0: straight to HALT, no pulse, done next cycle
        issue(2'b10, 8'd0, 4'd3);
        expect_cyc(S_HALT, 1'b0, 1'b1);
        expect_cyc(S_HALT, 1'b0, 1'b0);
        accept_step("burst0");
        step("burst0");
        chk("burst0_ce_count", bus.ce_count, 32'd9);

        // Burst 10, div 1, pre-empted by halt on the edge of the 3rd pulse
        issue(2'b10, 8'd10, 4'd1);
        for (int k = 1; k <= 6; k++) expect_cyc(S_BURST, (k % 2) == 0, 1'b0);
        accept_step("burst_preempt");
        repeat (5) step("burst_preempt");
        issue(2'b00, 8'd0, 4'd0);
        repeat (2) expect_cyc(S_HALT, 1'b0, 1'b0);
        accept_step("preempt_halt");
        step("preempt_halt");
        chk("preempt_ce_count", bus.ce_count, 32'd12);

        // Command accepted on the final burst pulse wins; no done
        issue(2'b10, 8'd2, 4'd0);
        repeat (2) expect_cyc(S_BURST, 1'b1, 1'b0);
        accept_step("burst_collide");
        step("burst_collide");
        issue(2'b01, 8'd0, 4'd0);
        repeat (2) expect_cyc(S_RUN, 1'b1, 1'b0);
        accept_step("collide_run");
        step("collide_run");
        chk("collide_ce_count", bus.ce_count, 32'd15);

        // Hardware reset mid-run aborts and clears ce_count
        rst = 1'b1;
        expect_cyc(S_RST, 1'b0, 1'b0);
        step("rst_midrun");
        chk("rst_midrun_ce_count", bus.ce_count, 32'd0);
        rst = 1'b0;
        repeat (3) expect_cyc(S_RST, 1'b0, 1'b0);
        expect_cyc(S_HALT, 1'b0, 1'b0);
        repeat (4) step("rst_midrun_stretch");

        // Run until ce_count reaches 7, then soft reset keeps it
        issue(2'b01, 8'd0, 4'd0);
        repeat (7) expect_cyc(S_RUN, 1'b1, 1'b0);
        accept_step("run_to7");
        repeat (6) step("run_to7");
        chk("run_to7_ce_count", bus.ce_count, 32'd6);
        issue(2'b11, 8'd0, 4'd0);
        repeat (4) expect_cyc(S_RST, 1'b0, 1'b0);
        expect_cyc(S_HALT, 1'b0, 1'b0);
        expect_cyc(S_HALT, 1'b0, 1'b0);
        accept_step("soft_rst");
        chk("soft_rst_ce_count", bus.ce_count, 32'd7);
        issue(2'b01, 8'd0, 4'd0);
        repeat (3) step("soft_rst_hold");
        bus.cmd_valid = 1'b0;
        step("soft_rst_exit");
        step("soft_rst_halt");
        chk("soft_rst_final_ce_count", bus.ce_count, 32'd7);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cpu_run_control.md
CPU_RUN_CONTROL -- requirements
Module: cpu_run_control

Interface
REQ-001 The block SHALL have parameter DIV_W, default 4, meaning the width of the clock-enable divider select.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the burst cycle count.
REQ-003 The block SHALL have parameter RST_CYCLES, default 4, meaning the number of cycles cpu_rst is held after reset is released (minimum 1).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: the synchronous, active-high reset.
REQ-007 The block SHALL have port cmd_valid, input, 1 bit: a command is presented.
REQ-008 The block SHALL have port cmd_ready, output, 1 bit: a command can be accepted.
REQ-009 The block SHALL have port cmd_op, input, 2 bits: 00 halt, 01 run, 10 burst, 11 soft reset.
REQ-010 The block SHALL have port cmd_count, input, CNT_W bits: the number of CPU cycles for a burst (step = 1).
REQ-011 The block SHALL have port div_sel, input, DIV_W bits: the cpu_ce period minus 1.
REQ-012 The block SHALL have port cpu_ce, output, 1 bit: the CPU clock-enable pulse.
REQ-013 The block SHALL have port cpu_rst, output, 1 bit: the stretched reset to the CPU.
REQ-014 The block SHALL have port state, output, 2 bits: 00 RESET, 01 HALT, 10 RUN, 11 BURST.
REQ-015 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a burst completes.
REQ-016 The block SHALL have port ce_count, output, 32 bits: the count of cpu_ce pulses since the last reset.

Function
REQ-017 The block SHALL accept a command on any rising edge where cmd_valid=1 and cmd_ready=1.
REQ-018 cmd_ready SHALL be 1 in HALT, RUN and BURST, and 0 in RESET.
REQ-019 On command acceptance, the block SHALL latch div_sel into div_q, clear the divider counter to 0, and latch cmd_count into the burst counter.
REQ-020 The divider counter SHALL increment on each cycle in RUN or BURST, and wrap to 0 after reaching div_q.
REQ-021 cpu_ce SHALL be 1 exactly when the state is RUN or BURST and the divider counter equals div_q, giving one pulse every div_q+1 cycles.
REQ-022 When div_q=0, cpu_ce SHALL be high on every cycle in RUN or BURST.
REQ-023 div_sel changes while no command is being accepted SHALL have no effect until the next accepted command.
REQ-024 In the HALT state, the block SHALL hold cpu_ce=0 and keep ce_count unchanged.
REQ-025 A halt command SHALL move the block to HALT on the acceptance edge, from any non-RESET state.
REQ-026 A run command SHALL move the block to RUN, which continues until another command is accepted.
REQ-027 A burst command with cmd_count>0 SHALL move the block to BURST.
REQ-028 In BURST, the burst counter SHALL decrement on each cpu_ce.
REQ-029 On the cpu_ce that takes the burst counter from 1 to 0, the block SHALL move to HALT on the same edge and pulse done=1 for the following cycle.
REQ-030 A burst command with cmd_count=0 SHALL move the block to HALT, produce no cpu_ce, and pulse done=1 in the next cycle.
REQ-031 A command accepted in RUN or BURST SHALL pre-empt the current operation immediately.
REQ-032 A pre-empted burst SHALL NOT pulse done.
REQ-033 If a command is accepted on the same edge as a final burst cpu_ce, the new command SHALL win and done SHALL NOT pulse.
REQ-034 A soft-reset command SHALL move the block to RESET with the reset counter cleared, identical to the hardware-reset sequence except that ce_count is retained.
REQ-035 In RESET, cpu_rst SHALL be 1 and cpu_ce SHALL be 0.
REQ-036 The block SHALL remain in RESET for exactly RST_CYCLES cycles after rst falls (or after soft-reset acceptance), then enter HALT with cpu_rst=0.
REQ-037 ce_count SHALL increment on each cpu_ce and wrap from 0xFFFFFFFF to 0.

Reset
REQ-038 While rst=1 at a rising edge, the block SHALL set state=RESET, reset counter=0, divider counter=0, burst counter=0, div_q=0, ce_count=0, done=0, cpu_rst=1, cpu_ce=0 and cmd_ready=0.
REQ-039 rst asserted mid-RUN or mid-BURST SHALL abort the operation on that edge with no done pulse.
REQ-040 Any cmd_valid present during rst or RESET SHALL be ignored.

Verification
REQ-041 The bench SHALL cover: rst held 3 cycles, then released -> cpu_rst=1 for exactly 4 further cycles, then state=01 with cmd_ready=1, cpu_ce=0 and ce_count=0.
REQ-042 The bench SHALL cover: run with div_sel=2, held for 12 cycles -> cpu_ce pulses on cycles 3, 6, 9 and 12 after acceptance, and ce_count=4.
REQ-043 The bench SHALL cover: burst with cmd_count=5 and div_sel=0 -> 5 consecutive cpu_ce pulses, state returns to 01, a single done pulse in the next cycle, and ce_count increases by 5.
REQ-044 The bench SHALL cover: burst with cmd_count=0 -> no cpu_ce, and done=1 for one cycle.
REQ-045 The bench SHALL cover: burst with cmd_count=10 and div_sel=1, pre-empted by halt after 3 cpu_ce -> state=01, no done pulse, and ce_count increases by 3.
REQ-046 The bench SHALL cover: soft reset during RUN with ce_count=7 -> cpu_rst=1 for 4 cycles, cmd_ready=0 throughout, then HALT with ce_count still 7.
